// File: rtl/dcpu16_alux.sv
// dcpu16_alux: multi-cycle DCPU16 execute ALU with a restoring divider for
// DIV/MOD, a valid/ready request port and a one-cycle completion pulse.
module dcpu16_alux #(
  parameter int DW = 16,
  parameter int CW = $clog2(2*DW+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [3:0]    opc,
  input  logic [DW-1:0] regA,
  input  logic [DW-1:0] regB,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] regR,
  output logic [DW-1:0] regO,
  output logic          CC
);

  typedef enum logic {IDLE, ITER} state_t;

  localparam logic [CW-1:0] LAST_MOD = CW'(DW - 1);
  localparam logic [CW-1:0] LAST_DIV = CW'(2*DW - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2*DW-1:0] dq, dq_nxt;      // dividend bits shifting out, quotient bits shifting in
  logic [DW-1:0]   rem, rem_nxt;    // partial remainder (always < divisor)
  logic [DW-1:0]   dvs, dvs_nxt;
  logic            is_div, is_div_nxt;
  logic [DW-1:0]   r_nxt, o_nxt;
  logic            cc_nxt, done_nxt;

  logic            accept;
  logic [DW:0]     add_full;
  logic [2*DW-1:0] mul_full, shl_full, shr_full;
  logic [DW:0]     part;
  logic            q_bit;
  logic [DW-1:0]   rem_step;
  logic [2*DW-1:0] dq_step;
  logic            last;

  assign busy   = (state == ITER);
  assign in_rdy = ~busy;
  assign accept = ena & in_vld & in_rdy;

  // Shift amounts of 2*DW or more naturally give zero in both halves.
  assign add_full = {1'b0, regA} + {1'b0, regB};
  assign mul_full = {{DW{1'b0}}, regA} * {{DW{1'b0}}, regB};
  assign shl_full = {{DW{1'b0}}, regA} << regB;
  assign shr_full = {regA, {DW{1'b0}}} >> regB;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign part     = {rem, dq[2*DW-1]};
  assign q_bit    = (part >= {1'b0, dvs});
  assign rem_step = q_bit ? DW'(part - {1'b0, dvs}) : part[DW-1:0];
  assign dq_step  = {dq[2*DW-2:0], q_bit};
  assign last     = (cnt == (is_div ? LAST_DIV : LAST_MOD));

  // Next-state, divider datapath and result selection.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dq_nxt     = dq;
    rem_nxt    = rem;
    dvs_nxt    = dvs;
    is_div_nxt = is_div;
    r_nxt      = regR;
    o_nxt      = regO;
    cc_nxt     = CC;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          done_nxt = 1'b1;
          cc_nxt   = (opc < 4'hC) ? 1'b1 : CC;
          case (opc)
            4'h0: r_nxt = regA;
            4'h1: r_nxt = regB;
            4'h2: begin
              r_nxt = add_full[DW-1:0];
              o_nxt = {{(DW-1){1'b0}}, add_full[DW]};
            end
            4'h3: begin
              r_nxt = regA - regB;
              o_nxt = (regA < regB) ? '1 : '0;
            end
            4'h4: begin
              r_nxt = mul_full[DW-1:0];
              o_nxt = mul_full[2*DW-1:DW];
            end
            4'h5, 4'h6: begin
              if (regB == '0) begin
                r_nxt = '0;
                if (opc == 4'h5) o_nxt = '0;
              end else begin
                done_nxt   = 1'b0;
                cc_nxt     = CC;
                state_nxt  = ITER;
                cnt_nxt    = '0;
                dq_nxt     = {regA, {DW{1'b0}}};
                rem_nxt    = '0;
                dvs_nxt    = regB;
                is_div_nxt = (opc == 4'h5);
              end
            end
            4'h7: begin
              r_nxt = shl_full[DW-1:0];
              o_nxt = shl_full[2*DW-1:DW];
            end
            4'h8: begin
              r_nxt = shr_full[2*DW-1:DW];
              o_nxt = shr_full[DW-1:0];
            end
            4'h9: r_nxt = regA & regB;
            4'hA: r_nxt = regA | regB;
            4'hB: r_nxt = regA ^ regB;
            4'hC: cc_nxt = (regA == regB);
            4'hD: cc_nxt = (regA != regB);
            4'hE: cc_nxt = (regA > regB);
            4'hF: cc_nxt = |(regA & regB);
            default: ;
          endcase
        end
      end
      ITER: begin
        dq_nxt  = dq_step;
        rem_nxt = rem_step;
        cnt_nxt = cnt + CW'(1);
        if (last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          cc_nxt    = 1'b1;
          if (is_div) begin
            r_nxt = dq_step[2*DW-1:DW];
            o_nxt = dq_step[DW-1:0];
          end else begin
            r_nxt = rem_step;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; everything freezes while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dq     <= '0;
      rem    <= '0;
      dvs    <= '0;
      is_div <= 1'b0;
      regR   <= '0;
      regO   <= '0;
      CC     <= 1'b0;
      done   <= 1'b0;
    end else if (ena) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dq     <= dq_nxt;
      rem    <= rem_nxt;
      dvs    <= dvs_nxt;
      is_div <= is_div_nxt;
      regR   <= r_nxt;
      regO   <= o_nxt;
      CC     <= cc_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dcpu16_alux.sv
// tb_dcpu16_alux: scoreboard bench for dcpu16_alux with an arithmetic
// reference model; directed cases followed by randomized requests.
module tb_dcpu16_alux;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, ena, in_vld;
  logic          in_rdy, busy, done, CC;
  logic [3:0]    opc;
  logic [DW-1:0] regA, regB, regR, regO;

  dcpu16_alux #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_vld(in_vld), .in_rdy(in_rdy),
    .opc(opc), .regA(regA), .regB(regB), .busy(busy), .done(done),
    .regR(regR), .regO(regO), .CC(CC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] o;
    logic          cc;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  logic          ena_q = 1'b0;
  logic [DW-1:0] m_r = '0, m_o = '0;
  logic          m_cc = 1'b0;

  // Cycle count and whether the most recent edge was enabled.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ena_q <= ena;
  end

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: each fresh done pulse retires the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1 && ena_q) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("R", regR, e.r);
        check("O", regO, e.o);
        check("CC", CC, e.cc);
        check("done_cycle", longint'(cyc), longint'(e.due));
      end
    end
  end

  // Reference model: updates R/O/CC architectural state and returns latency.
  task automatic model(input logic [3:0] op, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       output int lat);
    longint unsigned a, b, m, t;
    a = 64'(av);
    b = 64'(bv);
    m = 64'd1 << DW;
    lat = 0;
    if (op < 4'hC) m_cc = 1'b1;
    case (op)
      4'h0: m_r = av;
      4'h1: m_r = bv;
      4'h2: begin t = a + b; m_r = DW'(t % m); m_o = (t >= m) ? DW'(1) : '0; end
      4'h3: begin m_r = DW'((a + m - b) % m); m_o = (a < b) ? DW'(m - 1) : '0; end
      4'h4: begin t = a * b; m_r = DW'(t % m); m_o = DW'(t / m); end
      4'h5: begin
        if (b == 0) begin m_r = '0; m_o = '0; end
        else begin m_r = DW'(a / b); m_o = DW'(((a * m) / b) % m); lat = 2*DW; end
      end
      4'h6: begin
        if (b == 0) m_r = '0;
        else begin m_r = DW'(a % b); lat = DW; end
      end
      4'h7: begin
        if (b >= 2*DW) begin m_r = '0; m_o = '0; end
        else begin t = a << b; m_r = DW'(t % m); m_o = DW'((t / m) % m); end
      end
      4'h8: begin
        if (b >= 2*DW) begin m_r = '0; m_o = '0; end
        else begin m_r = DW'(a >> b); m_o = DW'(((a * m) >> b) % m); end
      end
      4'h9: m_r = DW'(a & b);
      4'hA: m_r = DW'(a | b);
      4'hB: m_r = DW'(a ^ b);
      4'hC: m_cc = (a == b);
      4'hD: m_cc = (a != b);
      4'hE: m_cc = (a > b);
      default: m_cc = ((a & b) != 0);
    endcase
  endtask

  // Drive one request at a negedge once ready; expected result is queued.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int extra);
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    while (in_rdy !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (in_rdy !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got in_rdy=%0b expected 1 within 200 cycles", in_rdy);
      return;
    end
    opc = op; regA = a; regB = b; in_vld = 1'b1;
    model(op, a, b, lat);
    e.r = m_r; e.o = m_o; e.cc = m_cc; e.due = cyc + 1 + lat + extra;
    sb.push_back(e);
    @(negedge clk);
    in_vld = 1'b0;
    opc = 4'($urandom); regA = DW'($urandom); regB = DW'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", longint'(sb.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]    op;
    logic [DW-1:0] a, b;
    rst = 1'b1; ena = 1'b1; in_vld = 1'b0; opc = '0; regA = '0; regB = '0;
    repeat (3) @(negedge clk);
    check("rst_R", regR, 0);
    check("rst_O", regO, 0);
    check("rst_CC", CC, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_rdy", in_rdy, 1);
    rst = 1'b0;
    @(negedge clk);

    // Carry/borrow, back to back.
    issue(4'h2, 16'hFFFF, 16'h0001, 0);
    issue(4'h3, 16'h0000, 16'h0001, 0);
    // Multiply and shifts, including an oversize shift amount.
    issue(4'h4, 16'hFFFF, 16'hFFFF, 0);
    issue(4'h8, 16'h8001, 16'd1, 0);
    issue(4'h7, 16'h8001, 16'd40, 0);
    drain();

    // Long divide; requests during busy must be ignored.
    issue(4'h5, 16'h0007, 16'h0002, 0);
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; opc = 4'h0; regA = 16'hDEAD;
      check("busy_during_div", busy, 1);
      check("in_rdy_during_div", in_rdy, 0);
      @(negedge clk);
    end
    in_vld = 1'b0;
    drain();

    // Remainder op, then divide and remainder by zero.
    issue(4'h6, 16'h0007, 16'h0003, 0);
    issue(4'h5, 16'h1234, 16'h0000, 0);
    issue(4'h2, 16'hFFFF, 16'h0003, 0);
    issue(4'h6, 16'h1234, 16'h0000, 0);
    // Compares.
    issue(4'hE, 16'h8000, 16'h7FFF, 0);
    issue(4'hF, 16'h00F0, 16'h000F, 0);
    issue(4'hC, 16'h5555, 16'h5555, 0);
    drain();

    // done holds while ena is low, then clears on the next enabled edge.
    issue(4'h0, 16'hABCD, 16'h0000, 0);
    ena = 1'b0;
    @(negedge clk);
    check("done_hold_ena_low", done, 1);
    check("R_hold_ena_low", regR, 16'hABCD);
    ena = 1'b1;
    @(negedge clk);
    check("done_cleared", done, 0);

    // Divide with ena dropped for 5 cycles mid-flight.
    issue(4'h5, 16'hBEEF, 16'h0123, 5);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    drain();

    // Reset mid-division aborts with no done.
    issue(4'h5, 16'h4321, 16'h0011, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    m_r = '0; m_o = '0; m_cc = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_R", regR, 0);
    check("abort_O", regO, 0);
    check("abort_CC", CC, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle_rdy", in_rdy, 1);

    // Randomized requests.
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom);
      a  = DW'($urandom);
      case ($urandom_range(0, 3))
        0: b = DW'($urandom_range(0, 40));
        1: b = '0;
        2: b = a;
        default: b = DW'($urandom);
      endcase
      issue(op, a, b, 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcpu16_alux.md
Name: dcpu16_alux

Overview:
Parametrised, multi-cycle successor to the DCPU16 execute ALU. It adds DIV and MOD through an iterative restoring divider, a generic datapath width, and a valid/ready request handshake with a completion pulse. It sits between operand fetch and register writeback. It drives the result register R, the overflow register O and the skip condition CC.

Parameters:
DW, 16, datapath width in bits (DW >= 4).
CW, $clog2(2*DW+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  clock, all flops rising-edge.
rst  in  1  synchronous, active-high reset.
ena  in  1  global enable; when low, every flop (state, counter, outputs) holds.
in_vld  in  1  request valid.
in_rdy  out  1  request ready; equals !busy.
opc  in  4  operation code.
regA  in  DW  operand a.
regB  in  DW  operand b.
busy  out  1  divider iteration in progress.
done  out  1  one-cycle pulse; R/O/CC updated on this edge.
regR  out  DW  result.
regO  out  DW  overflow register.
CC  out  1  condition (1 = execute next instruction).

Behaviour:
- Reset values: regR=0, regO=0, CC=0, done=0, busy=0, state=IDLE, counter=0.
- Accept = ena & in_vld & in_rdy. opc, regA and regB are captured at accept; later changes to them are ignored.
- Single-cycle ops complete on the accept edge: done=1 the following cycle. Back-to-back accepts every cycle are legal.
- Op set (M = 2^DW):
  - 0: R=a.
  - 1: R=b.
  - 2 ADD: R=(a+b) mod M; O=1 on carry, else 0.
  - 3 SUB: R=(a-b) mod M; O=all-ones on borrow, else 0.
  - 4 MUL: unsigned 2DW product; R=low half, O=high half.
  - 5 DIV: R=a/b; O=((a<<DW)/b) mod M.
  - 6 MOD: R=a%b; O unchanged.
  - 7 SHL: R=(a<<b) mod M; O=((a<<b)>>DW) mod M.
  - 8 SHR: R=a>>b; O=((a<<DW)>>b) mod M.
  - 9/A/B: AND/OR/XOR; O unchanged.
  - C IFE: CC=(a==b). D IFN: CC=(a!=b). E IFG: CC=(a>b), unsigned. F IFB: CC=|(a&b).
- Shift amount b is the full DW-bit value. Any b >= 2*DW yields R=0, O=0.
- CC is written to 1 on completion of every non-compare op. R is unchanged by compare ops. O holds unless written by the op.
- DIV/MOD with b==0 is single-cycle: DIV gives R=0, O=0; MOD gives R=0, O unchanged.
- DIV/MOD with b!=0 follows this FSM: IDLE -> ITER on accept, busy=1.
  - Dividend is the 2DW-bit value {a, DW'b0}. Restoring algorithm, 1 quotient bit per enabled cycle, MSB first. Partial remainder is DW+1 bits.
  - MOD: after DW iterations, R=remainder, done, back to IDLE. Latency DW cycles from accept to done.
  - DIV: after 2*DW iterations, R=quotient[2DW-1:DW], O=quotient[DW-1:0], done, back to IDLE. Latency 2*DW cycles.
  - in_rdy=0 while busy. in_vld during busy is ignored, not queued.
- With ena low, the FSM and counter freeze. done, if high, stays high until the next enabled edge. Latency extends by the number of ena-low cycles.
- Reset mid-operation aborts the division: all outputs return to their reset values, and no done is generated.

Test Plan:
1. ADD a=0xFFFF b=0x0001 -> next cycle done=1, R=0x0000, O=0x0001, CC=1. Follow with SUB a=0x0000 b=0x0001 on the next cycle -> R=0xFFFF, O=0xFFFF.
2. MUL 0xFFFF*0xFFFF -> R=0x0001, O=0xFFFE. SHR a=0x8001 b=1 -> R=0x4000, O=0x8000. SHL a=0x8001 b=40 -> R=0, O=0.
3. DIV a=0x0007 b=0x0002 -> busy for 32 cycles, in_rdy=0, done at cycle 32, R=0x0003, O=0x8000. A second in_vld asserted while busy is not accepted.
4. MOD a=0x0007 b=0x0003 -> done after 16 cycles, R=0x0001, O unchanged. DIV a=0x1234 b=0 -> single cycle, R=0, O=0. MOD by 0 -> R=0, O unchanged.
5. IFG a=0x8000 b=0x7FFF -> CC=1. IFB a=0x00F0 b=0x000F -> CC=0. IFE equal operands -> CC=1, R unchanged.
6. DIV in flight: drop ena for 5 cycles -> done arrives at cycle 37 with correct result. Separate run: assert rst at cycle 10 -> busy=0, R=0, O=0, CC=0, no done pulse.
